// File: rtl/mux_rotate_engine_pkg.sv
// ============================================================================
// Module  : mux_rotate_engine_pkg
// Purpose : Shared mode codes and FSM state encoding for mux_rotate_engine.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_rotate_engine_pkg;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;
    localparam logic [1:0] MODE_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_rotate_engine_mux_n.sv
// ============================================================================
// Module  : mux_n
// Purpose : Combinational N:1 word selector; an out-of-range index picks word 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_n #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 2,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [WIDTH-1:0]         o_data
);

    always_comb begin
        o_data = i_data[WIDTH-1:0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data = i_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rotate_engine.sv
// ============================================================================
// Module  : mux_rotate_engine
// Purpose : Select a source word, rotate/shift it one bit per cycle, and hand
//           the result out over a valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_rotate_engine
    import mux_rotate_engine_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 2,
    localparam int SEL_W  = $clog2(NUM_SRC),
    localparam int AMT_W  = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [1:0]               mode,
    input  logic [AMT_W-1:0]         amount,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         q,
    output logic                     busy
);

    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("mux_rotate_engine: WIDTH must be a power of two >= 2");
        end
        if (NUM_SRC < 2) begin : g_bad_num_src
            $error("mux_rotate_engine: NUM_SRC must be >= 2");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic [1:0]         r_mode;
    logic [AMT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_sel_word;
    logic [WIDTH-1:0]   w_step;

    mux_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) u_mux (
        .i_data (src_data),
        .i_sel  (src_sel),
        .o_data (w_sel_word)
    );

    always_comb begin
        w_step = r_q;
        case (r_mode)
            MODE_ROL: w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ROR: w_step = {r_q[0], r_q[WIDTH-1:1]};
            MODE_SLL: w_step = {r_q[WIDTH-2:0], 1'b0};
            MODE_SRA: w_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            default:  w_step = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_mode  <= MODE_ROL;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_q     <= w_sel_word;
                        r_mode  <= mode;
                        r_cnt   <= amount;
                        r_state <= (amount == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_q   <= w_step;
                    r_cnt <= r_cnt - AMT_W'(1);
                    // The step taken while cnt==1 is the final one.
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign q         = r_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_rotate_engine.sv
// ============================================================================
// Module  : tb_mux_rotate_engine
// Purpose : Self-checking bench for mux_rotate_engine (WIDTH=8, NUM_SRC=2 and 3).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_rotate_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] src_data = '0;
    logic        src_sel = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  amount = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  q;
    logic        busy;

    logic        d3_in_valid = 1'b0;
    logic        d3_in_ready;
    logic [23:0] d3_src_data = '0;
    logic [1:0]  d3_src_sel = '0;
    logic        d3_out_valid;
    logic        d3_out_ready = 1'b0;
    logic [7:0]  d3_q;
    logic        d3_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_rotate_engine #(.WIDTH(8), .NUM_SRC(2)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_data  (src_data),
        .src_sel   (src_sel),
        .mode      (mode),
        .amount    (amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .busy      (busy)
    );

    mux_rotate_engine #(.WIDTH(8), .NUM_SRC(3)) dut3 (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .src_data  (d3_src_data),
        .src_sel   (d3_src_sel),
        .mode      (2'b00),
        .amount    (3'd0),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .q         (d3_q),
        .busy      (d3_busy)
    );

    // Reference: apply the whole rotate/shift in one arithmetic expression.
    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [1:0] m, input int a);
        logic [7:0] r;
        case (m)
            2'b00:   r = (x << a) | (x >> (8 - a));
            2'b01:   r = (x >> a) | (x << (8 - a));
            2'b10:   r = x << a;
            default: r = 8'($signed(x) >>> a);
        endcase
        return r;
    endfunction

    // Issue one request, scramble inputs after accept, wait (bounded) for out_valid.
    task automatic run_op(input logic [1:0] m, input int amt, input logic sel,
                          input logic [7:0] s0, input logic [7:0] s1,
                          output logic [7:0] qo, output int cyc);
        @(negedge clk);
        in_valid = 1'b1;
        src_data = {s1, s0};
        src_sel  = sel;
        mode     = m;
        amount   = 3'(amt);
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        in_valid = 1'b0;
        src_data = 16'($urandom);
        src_sel  = 1'($urandom);
        mode     = 2'($urandom);
        amount   = 3'($urandom);
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        qo = q;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (q !== 8'h00)      begin bad++; $display("FAIL reset_q got=%h want=00", q); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [7:0] qo;
        int cyc;
        run_op(2'b00, 3, 1'b0, 8'hA5, 8'h00, qo, cyc);
        total++; if (cyc !== 4)     begin bad++; $display("FAIL rol3_latency got=%0d want=4", cyc); end
        total++; if (qo !== 8'h2D)  begin bad++; $display("FAIL rol3_q got=%h want=2d", qo); end
        release_result();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rol3_idle got=%b want=1", in_ready); end
        run_op(2'b01, 1, 1'b1, 8'h00, 8'h81, qo, cyc);
        total++; if (cyc !== 2)     begin bad++; $display("FAIL ror1_latency got=%0d want=2", cyc); end
        total++; if (qo !== 8'hC0)  begin bad++; $display("FAIL ror1_q got=%h want=c0", qo); end
        release_result();
        run_op(2'b11, 2, 1'b0, 8'h90, 8'h11, qo, cyc);
        total++; if (qo !== 8'hE4)  begin bad++; $display("FAIL sra2_q got=%h want=e4", qo); end
        release_result();
        run_op(2'b10, 7, 1'b1, 8'h22, 8'hFF, qo, cyc);
        total++; if (qo !== 8'h80)  begin bad++; $display("FAIL sll7_q got=%h want=80", qo); end
        total++; if (cyc !== 8)     begin bad++; $display("FAIL sll7_latency got=%0d want=8", cyc); end
        release_result();
    endtask

    task automatic test_hold();
        logic [7:0] qo;
        int cyc;
        run_op(2'b01, 0, 1'b0, 8'h3C, 8'hC3, qo, cyc);
        total++; if (cyc !== 1)    begin bad++; $display("FAIL amt0_latency got=%0d want=1", cyc); end
        total++; if (qo !== 8'h3C) begin bad++; $display("FAIL amt0_q got=%h want=3c", qo); end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            src_data = 16'h5555;
            @(posedge clk);
            @(negedge clk);
            total++;
            if (q !== 8'h3C || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL hold_%0d got q=%h ov=%b ir=%b busy=%b want q=3c ov=1 ir=0 busy=1",
                         i, q, out_valid, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        release_result();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL hold_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_out_of_range();
        int cyc;
        @(negedge clk);
        d3_in_valid = 1'b1;
        d3_src_data = {8'h77, 8'h66, 8'h5A};
        d3_src_sel  = 2'd3;
        @(posedge clk);
        @(negedge clk);
        d3_in_valid = 1'b0;
        cyc = 0;
        while (!d3_out_valid && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        total++; if (d3_q !== 8'h5A) begin bad++; $display("FAIL sel_oor_q got=%h want=5a", d3_q); end
        d3_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d3_in_valid = 1'b1;
        d3_src_sel  = 2'd2;
        @(posedge clk);
        @(negedge clk);
        d3_in_valid = 1'b0;
        total++; if (d3_q !== 8'h77) begin bad++; $display("FAIL sel2_q got=%h want=77", d3_q); end
        @(posedge clk);
        @(negedge clk);
        d3_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] qo;
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        src_data = 16'h00F3;
        src_sel  = 1'b0;
        mode     = 2'b00;
        amount   = 3'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (q !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset got q=%h ir=%b busy=%b want q=00 ir=1 busy=0", q, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 7, 1'b0, 8'h01, 8'hAA, qo, cyc);
        total++; if (qo !== 8'h80) begin bad++; $display("FAIL post_reset_rol7 got=%h want=80", qo); end
        release_result();
    endtask

    task automatic test_random();
        logic [7:0] qo, s0, s1, exp;
        logic [1:0] m;
        logic       sel;
        int         amt, cyc, hold;
        for (int n = 0; n < 40; n++) begin
            s0   = 8'($urandom);
            s1   = 8'($urandom);
            m    = 2'($urandom);
            sel  = 1'($urandom);
            amt  = $urandom_range(0, 7);
            exp  = ref_op(sel ? s1 : s0, m, amt);
            run_op(m, amt, sel, s0, s1, qo, cyc);
            total++;
            if (qo !== exp || cyc !== amt + 1) begin
                bad++;
                $display("FAIL rand_%0d m=%0d amt=%0d got q=%h lat=%0d want q=%h lat=%0d",
                         n, m, amt, qo, cyc, exp, amt + 1);
            end
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            total++;
            if (q !== exp || out_valid !== 1'b1) begin
                bad++; $display("FAIL rand_hold_%0d got q=%h ov=%b want q=%h ov=1", n, q, out_valid, exp);
            end
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qo;
        int cyc;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b want=1", n, in_ready); end
            run_op(2'b01, n, 1'b1, 8'h00, 8'h0F, qo, cyc);
            total++;
            if (qo !== ref_op(8'h0F, 2'b01, n) || cyc !== n + 1) begin
                bad++; $display("FAIL b2b_%0d got q=%h lat=%0d want q=%h lat=%0d",
                                n, qo, cyc, ref_op(8'h0F, 2'b01, n), n + 1);
            end
            @(posedge clk);
        end
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_out_of_range();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
